// File: rtl/game_pkg.sv
// Shared tic-tac-toe definitions: key codes, board width, press FSM states
// and the board occupancy helper used by the keypad and game-state blocks.
package game_pkg;

   localparam int         BOARD_W  = 18;
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_ZERO = 4'd11;
   localparam logic [3:0] KEY_HASH = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_HELD = 2'd2
   } press_state_e;

   // Cell k owns bits 18-2k (X) and 19-2k (O); anything that is not a cell
   // is reported as occupied so callers can never place a mark there.
   function automatic logic cell_occupied(input logic [BOARD_W-1:0] board,
                                          input logic [3:0]         code);
      logic [4:0] lo;
      logic       occ;
      lo = 5'd18 - {code, 1'b0};
      case (code)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
            occ = board[lo] | board[lo + 5'd1];
         KEY_STAR, KEY_ZERO, KEY_HASH:
            occ = 1'b1;
         default:
            occ = 1'b1;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debouncer: a keypad frame is accepted once it has repeated
// unchanged for DEBOUNCE_FRAMES consecutive full scans.
module key_debounce #(
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] frame,
   input  logic        frame_done,
   output logic [11:0] deb_frame,
   output logic        deb_upd
);

   localparam int            CW      = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

   logic [11:0]   prev_frame_q, prev_frame_d;
   logic [11:0]   deb_frame_q,  deb_frame_d;
   logic [CW-1:0] stable_cnt_q, stable_cnt_d;

   // Stability counting and acceptance, evaluated once per completed frame
   always_comb begin
      prev_frame_d = prev_frame_q;
      stable_cnt_d = stable_cnt_q;
      deb_frame_d  = deb_frame_q;
      deb_upd      = 1'b0;
      if (frame_done) begin
         if (frame != prev_frame_q) begin
            stable_cnt_d = {CW{1'b0}};
         end else if (stable_cnt_q == CNT_MAX) begin
            stable_cnt_d = stable_cnt_q;
         end else begin
            stable_cnt_d = stable_cnt_q + CW'(1);
         end
         prev_frame_d = frame;
         // Fire only on the frame that reaches the threshold, not while saturated
         if ((stable_cnt_d == CNT_MAX) && (stable_cnt_q != CNT_MAX)) begin
            deb_upd     = 1'b1;
            deb_frame_d = frame;
         end else begin
            deb_upd     = 1'b0;
            deb_frame_d = deb_frame_q;
         end
      end else begin
         deb_upd = 1'b0;
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_frame_q <= 12'd0;
         deb_frame_q  <= 12'd0;
         stable_cnt_q <= {CW{1'b0}};
      end else begin
         prev_frame_q <= prev_frame_d;
         deb_frame_q  <= deb_frame_d;
         stable_cnt_q <= stable_cnt_d;
      end
   end

   // Forward the new frame in the update cycle so the FSM decides without delay
   assign deb_frame = deb_upd ? frame : deb_frame_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column scan, row sampling, debounce and a press FSM
// that emits one legal-move strobe (or one reject strobe) per physical press.
module keypad_scanner
   import game_pkg::*;
#(
   parameter int SCAN_DIV        = 25000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [BOARD_W-1:0] board,
   input  logic [3:0]         key_row,
   output logic [2:0]         key_col,
   output logic [3:0]         key_data,
   output logic               key_valid,
   output logic               key_reject
);

   localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [3:0]       row_meta_q, row_sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [2:0]       key_col_q, key_col_d;
   logic [11:0]      frame_q, frame_d;
   press_state_e     state_q, state_d;
   logic [3:0]       key_data_q, key_data_d;
   logic             key_valid_q, key_valid_d;
   logic             key_reject_q, key_reject_d;

   logic             tick_s, frame_done_s;
   logic [11:0]      deb_frame_s;
   logic             deb_upd_s;
   logic [3:0]       code_s;
   logic             single_s, accept_s;

   assign tick_s       = (cnt_q == CNT_LAST);
   assign frame_done_s = tick_s && (col_q == 2'd2);

   // Two-flop synchronizer for the asynchronous row sense lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q <= 4'd0;
         row_sync_q <= 4'd0;
      end else begin
         row_meta_q <= key_row;
         row_sync_q <= row_meta_q;
      end
   end

   // Dwell counter, column stepping and end-of-dwell row sampling
   always_comb begin
      cnt_d     = cnt_q;
      col_d     = col_q;
      key_col_d = key_col_q;
      frame_d   = frame_q;
      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
         if (col_q == 2'd2) begin
            col_d = 2'd0;
         end else begin
            col_d = col_q + 2'd1;
         end
         case (col_q)
            2'd0:    {frame_d[9],  frame_d[6], frame_d[3], frame_d[0]} = row_sync_q;
            2'd1:    {frame_d[10], frame_d[7], frame_d[4], frame_d[1]} = row_sync_q;
            2'd2:    {frame_d[11], frame_d[8], frame_d[5], frame_d[2]} = row_sync_q;
            default: frame_d = frame_q;
         endcase
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      case (col_d)
         2'd0:    key_col_d = 3'b110;
         2'd1:    key_col_d = 3'b101;
         2'd2:    key_col_d = 3'b011;
         default: key_col_d = 3'b110;
      endcase
   end

   // Scan state registers; the debouncer sees the frame including this tick's column
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= {CNT_W{1'b0}};
         col_q     <= 2'd0;
         key_col_q <= 3'b110;
         frame_q   <= 12'd0;
      end else begin
         cnt_q     <= cnt_d;
         col_q     <= col_d;
         key_col_q <= key_col_d;
         frame_q   <= frame_d;
      end
   end

   key_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame     (frame_d),
      .frame_done(frame_done_s),
      .deb_frame (deb_frame_s),
      .deb_upd   (deb_upd_s)
   );

   // Key code of the highest set bit; only meaningful when exactly one is set
   always_comb begin
      code_s = 4'd0;
      for (int i = 0; i < 12; i++) begin
         code_s = deb_frame_s[i] ? 4'(i + 1) : code_s;
      end
   end

   assign single_s = (deb_frame_s != 12'd0) &&
                     ((deb_frame_s & (deb_frame_s - 12'd1)) == 12'd0);
   assign accept_s = single_s && !cell_occupied(board, code_s);

   // Press FSM next-state and strobe decision
   always_comb begin
      state_d      = state_q;
      key_data_d   = key_data_q;
      key_valid_d  = 1'b0;
      key_reject_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (deb_upd_s && (deb_frame_s != 12'd0)) begin
               state_d = enable ? ST_EVAL : ST_HELD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVAL: begin
            state_d = ST_HELD;
            if (accept_s) begin
               key_valid_d = 1'b1;
               key_data_d  = code_s;
            end else begin
               key_reject_d = 1'b1;
            end
         end
         ST_HELD: begin
            if (deb_upd_s && (deb_frame_s == 12'd0)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HELD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Press FSM state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         key_data_q   <= 4'd0;
         key_valid_q  <= 1'b0;
         key_reject_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_data_q   <= key_data_d;
         key_valid_q  <= key_valid_d;
         key_reject_q <= key_reject_d;
      end
   end

   assign key_col    = key_col_q;
   assign key_data   = key_data_q;
   assign key_valid  = key_valid_q;
   assign key_reject = key_reject_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream input stage for the tic-tac-toe game logic. Scans the 3×4 matrix keypad, debounces it, and converts a clean press of keys 1–9 into a single-cycle move strobe with a 4-bit cell code. Presses on occupied cells, non-cell keys (`*`, `0`, `#`) and multi-key chords are rejected. The game-state block therefore only ever receives legal moves, one per physical press.

## Interface
Parameters:
- `SCAN_DIV`, default 25000: clocks per column dwell (1 ms at 25 MHz).
- `DEBOUNCE_FRAMES`, default 5: consecutive identical full-scan frames needed to accept a key state.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: game active. When low, presses are consumed silently.
- `board` in 18: occupancy map. Cell k (1..9) uses bits `18-2k` (X) and `19-2k` (O). The cell is occupied if either bit is 1.
- `key_row` in 4: row sense, active-high, asynchronous to `clk`.
- `key_col` out 3: column drive, active-low, exactly one bit low at a time.
- `key_data` out 4: last accepted cell code, 1..9. Holds its value between accepts.
- `key_valid` out 1: one-cycle pulse on an accepted move.
- `key_reject` out 1: one-cycle pulse on a rejected press.

## Operation
- **Row synchronizer**: `key_row` passes through a 2-flop synchronizer before any use.
- **Scan counter**:
  - Counts 0..`SCAN_DIV`-1. `tick` is asserted on the terminal count.
  - Column index `col` cycles 0→1→2→0 on each `tick`.
  - `key_col` = ~(1<<`col`).
- **Sampling**:
  - On `tick`, the synchronized rows are written into `frame[3r+col]`.
  - The sample is taken at the end of the dwell, which gives the rows settling time.
  - `frame_done` is asserted on the `tick` where `col`=2.
- **Key map**:
  - Row r, column c gives code 3r+c+1 for r<3, i.e. keys 1..9.
  - Row 3 gives codes 10 (`*`), 11 (`0`), 12 (`#`). These are never accepted.
- **Debounce** (on each `frame_done`):
  - If `frame` equals `prev_frame`, `stable_cnt` increments, saturating at `DEBOUNCE_FRAMES`. Otherwise `stable_cnt` is set to 0.
  - `prev_frame` is then set to `frame`.
  - When `stable_cnt` reaches `DEBOUNCE_FRAMES`, `deb_frame` is set to `frame` and `deb_upd` pulses for one cycle.
- **Press FSM** (states IDLE, EVAL, HELD):
  - IDLE → EVAL on `deb_upd` with `deb_frame`≠0 and `enable`=1.
  - IDLE → HELD on `deb_upd` with `deb_frame`≠0 and `enable`=0. No pulse is generated.
  - EVAL → HELD, always, after exactly one cycle. The EVAL decision is:
    - exactly one bit set, code 1..9, and cell unoccupied in `board` sampled this cycle: `key_valid`=1 and `key_data`=code.
    - otherwise (multi-key, code ≥10, or occupied): `key_reject`=1, and `key_data` is unchanged.
  - HELD → IDLE on `deb_upd` with `deb_frame`=0, regardless of `enable`.
- **Re-arming**: a held key never re-fires. A new pulse requires a debounced release followed by a debounced press.

## Timing
- **Reset values**: `key_col`=3'b110, `key_data`=0, `key_valid`=0, `key_reject`=0. FSM in IDLE. All counters, `frame`, `prev_frame` and `deb_frame` cleared.
- **Reset mid-press**: returns to IDLE.
  - A key still held after reset is accepted once it is debounced. This is intended, because `board` is also cleared at game reset.
- **Latency**:
  - `deb_upd` occurs on the `frame_done` cycle.
  - EVAL follows one cycle later, and `key_valid`/`key_reject` are registered in that EVAL cycle.
  - From a clean stable press to pulse: at most (`DEBOUNCE_FRAMES`+2)·3·`SCAN_DIV`+4 clocks.
- **Pulse exclusivity**: `key_valid` and `key_reject` are never high together. Each is high for exactly one clock.
- **Bounce**: any frame change restarts the count. A glitch shorter than one frame may be missed entirely; this is acceptable.
- **`board` timing**: only sampled in EVAL. Changes to `board` at any other time have no effect.
- **`enable` timing**: only checked on the IDLE→EVAL/HELD decision. If `enable` drops during EVAL, that evaluation still completes.

## Structure
- Shared package `game_pkg`:
  - constants `KEY_STAR`=10, `KEY_ZERO`=11, `KEY_HASH`=12, `BOARD_W`=18
  - FSM state enum
  - function `cell_occupied(board, code)`, used by both the game-state block and this block.
- One sub-module, `key_debounce`:
  - inputs: `frame`, `frame_done`
  - outputs: `deb_frame`, `deb_upd`
  - holds `prev_frame` and `stable_cnt`.
- Scan counter, synchronizer and FSM live in the top module.

## Test plan
Run the bench with `SCAN_DIV`=4 and `DEBOUNCE_FRAMES`=3, and a behavioural keypad model that drives `key_row` from `key_col`.
- **Reset**: assert `rst_n`=0 mid-scan → `key_col`=110, `key_data`=0, no pulses. Release reset → `key_col` walks 110→101→011 every 4 clocks.
- **Accepted move**: hold key 5 (r1,c1) with `board`=0 and `enable`=1 → exactly one `key_valid` with `key_data`=5, none for 20 further frames while held. Release then re-press → a second single pulse.
- **Bounce**: toggle key 2 every frame for 10 frames → no `key_valid` and no `key_reject`. Hold it steady → one `key_valid` with `key_data`=2.
- **Occupied and non-cell keys**:
  - `board[10]`=1, press key 4 → `key_reject`, `key_data` keeps its previous value.
  - Press `#` → `key_reject`.
- **Enable gating**: press 7 with `enable`=0, raise `enable` while still held → no pulse. Release and re-press → `key_valid` with `key_data`=7.
- **Chord**: press 1 and 9 together → one `key_reject` and no `key_valid`. Release both → FSM back to IDLE.
